// File: rtl/peripheral_mpi_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one MPI peripheral slave port among MASTERS requesters,
// with an ack watchdog that ends hung transfers with an error to the owning master.
module peripheral_mpi_wb_arbiter #(
    parameter int unsigned MASTERS = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [MASTERS*3-1:0]   m_adr_i,
    input  logic [MASTERS*8-1:0]   m_dat_i,
    input  logic [MASTERS-1:0]     m_we_i,
    input  logic [MASTERS-1:0]     m_stb_i,
    input  logic [MASTERS-1:0]     m_cyc_i,
    input  logic [MASTERS*4-1:0]   m_sel_i,
    output logic [7:0]             m_dat_o,
    output logic [MASTERS-1:0]     m_ack_o,
    output logic [MASTERS-1:0]     m_err_o,
    output logic [2:0]             s_adr_o,
    output logic [7:0]             s_dat_o,
    output logic                   s_we_o,
    output logic                   s_stb_o,
    output logic                   s_cyc_o,
    output logic [3:0]             s_sel_o,
    input  logic [7:0]             s_dat_i,
    input  logic                   s_ack_i,
    output logic [MASTERS-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int unsigned PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      wdog_q, wdog_d;
    logic [PW-1:0]      owner, owner_next, winner;
    logic               owner_cyc, owner_stb, timeout;

    always_comb begin
        owner = '0;
        for (int unsigned k = 0; k < MASTERS; k++) begin
            if (grant_q[k]) owner = PW'(k);
        end
    end

    // Scan from the highest offset down so the requester nearest the pointer is assigned last.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = rr_q;
        for (int i = int'(MASTERS) - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % MASTERS;
            if (m_cyc_i[idx]) winner = PW'(idx);
        end
    end

    assign owner_cyc  = m_cyc_i[owner];
    assign owner_stb  = m_stb_i[owner];
    assign owner_next = (owner == PW'(MASTERS - 1)) ? '0 : owner + 1'b1;
    // A same-cycle ack beats the watchdog.
    assign timeout    = (state_q == StGrant) && owner_stb && !s_ack_i &&
                        (wdog_q == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wdog_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    state_d = StGrant;
                    grant_d = MASTERS'(1) << winner;
                end
            end
            StGrant: begin
                if (!owner_cyc || timeout) begin
                    state_d = StIdle;
                    grant_d = '0;
                    rr_d    = owner_next;
                end else if (owner_stb && !s_ack_i) begin
                    wdog_d = (wdog_q == CW'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_sel_o = '0;
        if (state_q == StGrant) begin
            s_adr_o        = m_adr_i[owner*3 +: 3];
            s_dat_o        = m_dat_i[owner*8 +: 8];
            s_we_o         = m_we_i[owner];
            s_sel_o        = m_sel_i[owner*4 +: 4];
            s_cyc_o        = owner_cyc;
            s_stb_o        = owner_stb && !timeout;
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = timeout;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == StGrant);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_peripheral_mpi_wb_arbiter.sv
// Bench for peripheral_mpi_wb_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against an owner/pointer/wait-count model of the arbiter.
module tb_peripheral_mpi_wb_arbiter;

    localparam int M  = 4;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] m_adr = '0;
    logic [31:0] m_dat = '0;
    logic [3:0]  m_we = '0, m_stb = '0, m_cyc = '0;
    logic [15:0] m_sel = '0;
    logic [7:0]  m_dat_o;
    logic [3:0]  m_ack, m_err;
    logic [2:0]  s_adr;
    logic [7:0]  s_dat_o;
    logic        s_we, s_stb, s_cyc;
    logic [3:0]  s_sel;
    logic [7:0]  s_dat_i = '0;
    logic        s_ack = 1'b0;
    logic [3:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: current owner (-1 when idle), round-robin pointer, consecutive unacked strobe cycles.
    int mo      = -1;
    int mptr    = 0;
    int mwait   = 0;
    bit started = 0;

    peripheral_mpi_wb_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_sel_i(m_sel), .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
        .s_sel_o(s_sel), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit model_timeout();
        return mo >= 0 && m_stb[mo] && mwait == TO && !s_ack;
    endfunction

    function automatic int first_req(input int ptr, input logic [3:0] c);
        for (int i = 0; i < M; i++) begin
            if (c[(ptr + i) % M]) return (ptr + i) % M;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mo = -1; mptr = 0; mwait = 0;
        end else if (mo < 0) begin
            mo = first_req(mptr, m_cyc); mwait = 0;
        end else if (!m_cyc[mo] || model_timeout()) begin
            mptr = (mo + 1) % M; mo = -1; mwait = 0;
        end else if (s_ack || !m_stb[mo]) begin
            mwait = 0;
        end else if (mwait < TO) begin
            mwait = mwait + 1;
        end
        started = 1;
    end

    initial forever begin
        logic [3:0] e_grant, e_ack, e_err;
        bit         to;
        @(negedge clk);
        if (started) begin
            to      = model_timeout();
            e_grant = '0;
            e_ack   = '0;
            e_err   = '0;
            if (mo >= 0) begin
                e_grant[mo] = 1'b1;
                e_ack[mo]   = s_ack;
                e_err[mo]   = to;
            end
            chk("grant", 32'(grant), 32'(e_grant));
            chk("busy", 32'(busy), 32'(mo >= 0));
            chk("m_ack", 32'(m_ack), 32'(e_ack));
            chk("m_err", 32'(m_err), 32'(e_err));
            chk("m_dat", 32'(m_dat_o), 32'(s_dat_i));
            chk("s_cyc", 32'(s_cyc), 32'(mo >= 0 && m_cyc[mo]));
            chk("s_stb", 32'(s_stb), 32'(mo >= 0 && m_stb[mo] && !to));
            chk("s_we", 32'(s_we), 32'(mo >= 0 && m_we[mo]));
            chk("s_adr", 32'(s_adr), (mo >= 0) ? 32'(m_adr[mo*3 +: 3]) : 32'd0);
            chk("s_dat", 32'(s_dat_o), (mo >= 0) ? 32'(m_dat[mo*8 +: 8]) : 32'd0);
            chk("s_sel", 32'(s_sel), (mo >= 0) ? 32'(m_sel[mo*4 +: 4]) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [2:0] adr, input logic [7:0] dat, input logic [3:0] sel);
        m_cyc[k]         = cyc;
        m_stb[k]         = stb;
        m_we[k]          = we;
        m_adr[k*3 +: 3]  = adr;
        m_dat[k*8 +: 8]  = dat;
        m_sel[k*4 +: 4]  = sel;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        // Master 2 single write, ack two cycles after the first granted strobe.
        set_m(2, 1, 1, 1, 3'h3, 8'h80, 4'h1);
        @(negedge clk); chk("d_idle_grant", 32'(grant), 32'h0);
        step();
        @(negedge clk);
        chk("d_grant2", 32'(grant), 32'b0100);
        chk("d_adr", 32'(s_adr), 32'h3);
        chk("d_dat", 32'(s_dat_o), 32'h80);
        step();
        step(); s_ack = 1'b1;
        @(negedge clk);
        chk("d_ack2", 32'(m_ack), 32'b0100);
        chk("d_noerr", 32'(m_err), 32'h0);
        step(); s_ack = 1'b0; set_m(2, 0, 0, 0, 3'h0, 8'h0, 4'h0);
        step(); set_m(0, 1, 1, 0, 3'h1, 8'h11, 4'hf); set_m(3, 1, 1, 0, 3'h6, 8'h33, 4'h2);
        @(negedge clk); chk("d_released", 32'(grant), 32'h0);
        step();
        @(negedge clk); chk("d_ptr3", 32'(grant), 32'b1000);
        // Reset while master 3 is mid-transfer.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("d_rst_grant", 32'(grant), 32'h0);
        chk("d_rst_cyc", 32'(s_cyc), 32'h0);
        chk("d_rst_busy", 32'(busy), 32'h0);
        step();
        @(negedge clk); chk("d_rr0", 32'(grant), 32'b0001);
        step(); set_m(0, 0, 0, 0, 3'h0, 8'h0, 4'h0);
        step();
        @(negedge clk); chk("d_gap", 32'(grant), 32'h0);
        step();
        @(negedge clk); chk("d_rr3", 32'(grant), 32'b1000);
        step(); set_m(3, 0, 0, 0, 3'h0, 8'h0, 4'h0);
        // Master 1 strobes with no ack: error on the fifth granted cycle.
        step(); set_m(1, 1, 1, 0, 3'h2, 8'h0, 4'h1);
        step(); step(); step(); step();
        @(negedge clk); chk("d_pre_err", 32'(m_err), 32'h0);
        step();
        @(negedge clk);
        chk("d_err1", 32'(m_err), 32'b0010);
        chk("d_err_stb", 32'(s_stb), 32'h0);
        step(); set_m(1, 0, 0, 0, 3'h0, 8'h0, 4'h0);
        @(negedge clk); chk("d_err_busy", 32'(busy), 32'h0);
        // Same again, but the ack lands on the timeout cycle.
        step(); set_m(1, 1, 1, 0, 3'h2, 8'h0, 4'h1);
        step(); step(); step(); step();
        step(); s_ack = 1'b1;
        @(negedge clk);
        chk("d_late_ack", 32'(m_ack), 32'b0010);
        chk("d_late_noerr", 32'(m_err), 32'h0);
        step(); s_ack = 1'b0; set_m(1, 0, 0, 0, 3'h0, 8'h0, 4'h0);
        // Master 2 owns while master 1 strobes; the ack goes only to 2.
        step(); set_m(2, 1, 1, 0, 3'h0, 8'h0, 4'h1); set_m(1, 1, 1, 0, 3'h5, 8'h0, 4'h1);
        step(); s_ack = 1'b1; s_dat_i = 8'hA5;
        @(negedge clk);
        chk("d_ack_owner", 32'(m_ack), 32'b0100);
        chk("d_rdata", 32'(m_dat_o), 32'hA5);
        step(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        step();

        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < M; k++) begin
                if (m_cyc[k]) m_cyc[k] = ($urandom_range(0, 9) != 0);
                else          m_cyc[k] = ($urandom_range(0, 5) == 0);
                m_stb[k] = m_cyc[k] && ($urandom_range(0, 7) != 0);
            end
            m_we    = 4'($urandom);
            m_adr   = 12'($urandom);
            m_dat   = $urandom;
            m_sel   = 16'($urandom);
            s_dat_i = 8'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
        end
        step();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
